// File: rtl/ofdm_map_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_map_pkg
// Shared definitions for the OFDM subcarrier allocation map, used by both the
// RX demapper and the TX mapper.
//   map_code_e     : 2-bit per-bin allocation code
//   FFTSIZE_DEF    : default bins per OFDM symbol
//   NUM_BW         : number of defined bandwidth selections (0..NUM_BW-1)
//   band_map_word  : 12-bit map word for one bin, band b in bits [2b+1:2b]
//   band_slice     : extracts one band's code from a map word
// Band map layout (signed frequency k, |k| = distance from DC):
//   |k| == 0                 -> null (DC)
//   1 <= |k| <= hw(b)        -> pilot when (|k| + 3b) mod 16 == 0, else data
//   |k| == hw(b) + 1         -> reserved (edge guard, treated as null)
//   otherwise                -> null
//   hw(b) = (b + 2) * fftsize / 16
// ---------------------------------------------------------------------------
package ofdm_map_pkg;

  typedef enum logic [1:0] {
    MAP_NULL  = 2'b00,
    MAP_DATA  = 2'b01,
    MAP_PILOT = 2'b10,
    MAP_RSVD  = 2'b11
  } map_code_e;

  localparam int FFTSIZE_DEF = 1024;
  localparam int NUM_BW      = 6;
  localparam int PILOT_STEP  = 16;

  // Full map word for one bin, all bands packed side by side.
  function automatic logic [2*NUM_BW-1:0] band_map_word(input int bin, input int fftsize);
    logic [2*NUM_BW-1:0] w;
    logic [1:0]          c;
    int                  k;
    int                  hw;
    w = '0;
    k = (bin < fftsize / 2) ? bin : fftsize - bin;
    for (int b = 0; b < NUM_BW; b++) begin
      hw = ((b + 2) * fftsize) / 16;
      if (bin >= fftsize || k == 0) begin
        c = MAP_NULL;
      end else if (k <= hw) begin
        c = (((k + 3 * b) % PILOT_STEP) == 0) ? MAP_PILOT : MAP_DATA;
      end else if (k == hw + 1) begin
        c = MAP_RSVD;
      end else begin
        c = MAP_NULL;
      end
      w[2*b +: 2] = c;
    end
    return w;
  endfunction

  // Band selections beyond NUM_BW-1 have no map entry and read as null.
  function automatic map_code_e band_slice(input logic [2*NUM_BW-1:0] word, input logic [2:0] band);
    map_code_e c;
    c = MAP_NULL;
    case (band)
      3'd0:    c = map_code_e'(word[1:0]);
      3'd1:    c = map_code_e'(word[3:2]);
      3'd2:    c = map_code_e'(word[5:4]);
      3'd3:    c = map_code_e'(word[7:6]);
      3'd4:    c = map_code_e'(word[9:8]);
      3'd5:    c = map_code_e'(word[11:10]);
      default: c = MAP_NULL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/subcarrier_map_lookup.sv
// ---------------------------------------------------------------------------
// subcarrier_map_lookup
// Registered map ROM read followed by the band slice. The code for the
// address presented in one cycle appears on o_code in the next cycle.
// Shared between the RX demapper and the TX mapper.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (o_code -> MAP_NULL)
//   i_addr    : {band[2:0], bin[DEPTH-1:0]}
//   o_code    : registered map code for the previous cycle's address
// ---------------------------------------------------------------------------
module subcarrier_map_lookup
  import ofdm_map_pkg::*;
#(
  parameter int DEPTH   = 10,
  parameter int FFTSIZE = FFTSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH+2:0] i_addr,
  output map_code_e        o_code
);

  logic [2*NUM_BW-1:0] w_word;
  logic [2:0]          w_band;
  map_code_e           r_code;

  assign w_band = i_addr[DEPTH+2:DEPTH];
  assign w_word = band_map_word(int'(i_addr[DEPTH-1:0]), FFTSIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= MAP_NULL;
    end else begin
      r_code <= band_slice(w_word, w_band);
    end
  end

  assign o_code = r_code;

endmodule

// File: rtl/subcarrier_demap.sv
// ---------------------------------------------------------------------------
// subcarrier_demap
// RX subcarrier demapper. Consumes the natural-order FFT bin stream, looks up
// each bin's allocation code for the latched bandwidth, drops null/reserved
// bins and forwards data and pilot carriers tagged with type and bin index.
//
// Build option: define SUBCARRIER_DEMAP_STATS_EN to build the per-symbol
// data/pilot counters; without it n_data and n_pilot are tied to 0.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   index_bw        : bandwidth select 0..5 (6,7 = all null), latched at bin 0
//   s_valid/s_ready : input bin handshake; s_i/s_q sample, s_last = bin FFTSIZE-1
//   m_valid/m_ready : output carrier handshake; m_i/m_q sample,
//                     m_pilot 1 = pilot / 0 = data, m_idx FFT bin index
//   sym_done        : 1-cycle pulse after bin FFTSIZE-1 leaves stage 1
//   sync_err        : 1-cycle pulse after a bin whose s_last disagrees with
//                     the bin counter
//   n_data/n_pilot  : data/pilot carriers in the last completed symbol
//
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// m_valid is high it stays high with m_i/m_q/m_pilot/m_idx unchanged until
// m_ready is seen. s_ready does not depend on s_valid.
// ---------------------------------------------------------------------------
module subcarrier_demap
  import ofdm_map_pkg::*;
#(
  parameter int DEPTH   = 10,
  parameter int FFTSIZE = FFTSIZE_DEF,
  parameter int DW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       index_bw,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_i,
  input  logic [DW-1:0]    s_q,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_i,
  output logic [DW-1:0]    m_q,
  output logic             m_pilot,
  output logic [DEPTH-1:0] m_idx,
  output logic             sym_done,
  output logic             sync_err,
  output logic [DEPTH:0]   n_data,
  output logic [DEPTH:0]   n_pilot
);

  localparam logic [DEPTH-1:0] LAST_BIN = DEPTH'(FFTSIZE - 1);

  // Input-side bookkeeping
  logic [DEPTH-1:0] r_bin;
  logic [2:0]       r_band;

  // Stage 0: accepted sample, its address is being looked up
  logic             r_s0_valid;
  logic [DW-1:0]    r_s0_i;
  logic [DW-1:0]    r_s0_q;
  logic [DEPTH-1:0] r_s0_idx;
  logic [2:0]       r_s0_band;

  // Stage 1: sample plus returned map code
  logic             r_s1_valid;
  logic [DW-1:0]    r_s1_i;
  logic [DW-1:0]    r_s1_q;
  logic [DEPTH-1:0] r_s1_idx;
  logic [2:0]       r_s1_band;

  logic             r_sym_done;
  logic             r_sync_err;

  map_code_e        w_s1_code;
  logic             w_s1_null;
  logic             w_adv;
  logic             w_accept;
  logic             w_s1_leave;
  logic             w_mismatch;
  logic [2:0]       w_bin_band;
  logic [DEPTH+2:0] w_addr;

  assign w_s1_null  = (w_s1_code == MAP_NULL) || (w_s1_code == MAP_RSVD);
  // Whole pipeline shifts together; a null bin in stage 1 never blocks.
  assign w_adv      = !r_s1_valid || m_ready || w_s1_null;
  assign w_accept   = s_valid && w_adv;
  assign w_s1_leave = r_s1_valid && w_adv;
  assign w_mismatch = s_last != (r_bin == LAST_BIN);
  // Bin 0 uses the live select, since the latch only updates on that edge.
  assign w_bin_band = (r_bin == '0) ? index_bw : r_band;

  // While stalled the stage-1 address is re-read so the registered code
  // keeps matching the held sample.
  assign w_addr = w_adv ? {r_s0_band, r_s0_idx} : {r_s1_band, r_s1_idx};

  subcarrier_map_lookup #(
    .DEPTH   (DEPTH),
    .FFTSIZE (FFTSIZE)
  ) u_lookup (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_addr),
    .o_code (w_s1_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin      <= '0;
      r_band     <= '0;
      r_s0_valid <= 1'b0;
      r_s0_i     <= '0;
      r_s0_q     <= '0;
      r_s0_idx   <= '0;
      r_s0_band  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_i     <= '0;
      r_s1_q     <= '0;
      r_s1_idx   <= '0;
      r_s1_band  <= '0;
      r_sym_done <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_accept && w_mismatch;
      r_sym_done <= w_s1_leave && (r_s1_idx == LAST_BIN);

      if (w_accept) begin
        if (r_bin == '0) begin
          r_band <= index_bw;
        end
        // A framing mismatch resynchronises: the next bin is bin 0.
        if (w_mismatch || (r_bin == LAST_BIN)) begin
          r_bin <= '0;
        end else begin
          r_bin <= r_bin + DEPTH'(1);
        end
      end

      if (w_adv) begin
        r_s1_valid <= r_s0_valid;
        r_s1_i     <= r_s0_i;
        r_s1_q     <= r_s0_q;
        r_s1_idx   <= r_s0_idx;
        r_s1_band  <= r_s0_band;
        r_s0_valid <= s_valid;
        if (s_valid) begin
          r_s0_i    <= s_i;
          r_s0_q    <= s_q;
          r_s0_idx  <= r_bin;
          r_s0_band <= w_bin_band;
        end
      end
    end
  end

  assign s_ready  = w_adv;
  assign m_valid  = r_s1_valid && !w_s1_null;
  assign m_i      = r_s1_i;
  assign m_q      = r_s1_q;
  assign m_idx    = r_s1_idx;
  assign m_pilot  = (w_s1_code == MAP_PILOT);
  assign sym_done = r_sym_done;
  assign sync_err = r_sync_err;

`ifdef SUBCARRIER_DEMAP_STATS_EN
  logic [DEPTH:0] r_acc_data;
  logic [DEPTH:0] r_acc_pilot;
  logic [DEPTH:0] r_n_data;
  logic [DEPTH:0] r_n_pilot;
  logic           w_inc_data;
  logic           w_inc_pilot;
  logic           w_sym_end;

  assign w_inc_data  = w_s1_leave && (w_s1_code == MAP_DATA);
  assign w_inc_pilot = w_s1_leave && (w_s1_code == MAP_PILOT);
  assign w_sym_end   = w_s1_leave && (r_s1_idx == LAST_BIN);

  // Totals publish on the same edge that raises sym_done and include the
  // final bin of the symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_data  <= '0;
      r_acc_pilot <= '0;
      r_n_data    <= '0;
      r_n_pilot   <= '0;
    end else if (w_sym_end) begin
      r_n_data    <= r_acc_data + (DEPTH+1)'(w_inc_data);
      r_n_pilot   <= r_acc_pilot + (DEPTH+1)'(w_inc_pilot);
      r_acc_data  <= '0;
      r_acc_pilot <= '0;
    end else begin
      r_acc_data  <= r_acc_data + (DEPTH+1)'(w_inc_data);
      r_acc_pilot <= r_acc_pilot + (DEPTH+1)'(w_inc_pilot);
    end
  end

  assign n_data  = r_n_data;
  assign n_pilot = r_n_pilot;
`else
  assign n_data  = '0;
  assign n_pilot = '0;
`endif

endmodule

// File: tb/tb_subcarrier_demap.sv
// ---------------------------------------------------------------------------
// tb_subcarrier_demap
// Self-checking bench for subcarrier_demap. The reference model places
// carriers by signed frequency distance from DC for each bandwidth, follows
// the framing rules of the demapper at transaction level, and queues the
// expected output carriers.
// ---------------------------------------------------------------------------
module tb_subcarrier_demap;

  localparam int DEPTH = 10;
  localparam int N     = 1024;
  localparam int DW    = 16;
  localparam int W     = 1 + DEPTH + 2 * DW;
`ifdef SUBCARRIER_DEMAP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       index_bw = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_i = '0;
  logic [DW-1:0]    s_q = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [DW-1:0]    m_i;
  logic [DW-1:0]    m_q;
  logic             m_pilot;
  logic [DEPTH-1:0] m_idx;
  logic             sym_done;
  logic             sync_err;
  logic [DEPTH:0]   n_data;
  logic [DEPTH:0]   n_pilot;

  always #5 clk = ~clk;

  subcarrier_demap #(.DEPTH(DEPTH), .FFTSIZE(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .index_bw (index_bw),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_i      (s_i),
    .s_q      (s_q),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_i      (m_i),
    .m_q      (m_q),
    .m_pilot  (m_pilot),
    .m_idx    (m_idx),
    .sym_done (sym_done),
    .sync_err (sync_err),
    .n_data   (n_data),
    .n_pilot  (n_pilot)
  );

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;      // 0: always ready, 1: 1-0-0-1 pattern, 2: random
  int acc_cyc = 0;
  int first_valid_cyc = -1;
  int first_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // reference model state
  int mdl_bin = 0;
  int mdl_band = 0;
  int cnt_d = 0;
  int cnt_p = 0;
  int exp_sym = 0;
  int exp_sync = 0;
  int exp_nd = 0;
  int exp_np = 0;

  // monitor counters
  int sym_cnt = 0;
  int sync_cnt = 0;
  int stall_viol = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_fields = '0;
  logic [W-1:0] mon_fields;

  assign mon_fields = {m_pilot, m_idx, m_i, m_q};

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (ph == 0) || (ph == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ((m_valid !== 1'b1) || (mon_fields !== prev_fields))) stall_viol++;
      if ((m_valid === 1'b1) && (first_valid_cyc < 0)) first_valid_cyc = cyc;
      if ((m_valid === 1'b1) && (m_ready === 1'b1)) got_q.push_back(mon_fields);
      if (sym_done === 1'b1) sym_cnt++;
      if (sync_err === 1'b1) sync_cnt++;
      prev_stall  = (m_valid === 1'b1) && (m_ready !== 1'b1);
      prev_fields = mon_fields;
    end
  end

  // ---------------- reference model ----------------
  // 0 null, 1 data, 2 pilot, 3 reserved
  function automatic int ref_code(int band, int bin);
    int f;
    int a;
    int lim;
    if (band >= 6) return 0;
    f   = (bin >= N / 2) ? bin - N : bin;
    a   = (f < 0) ? -f : f;
    lim = N * (band + 2) / 16;
    if (a == 0) return 0;
    if (a <= lim) return (((a + 3 * band) % 16) == 0) ? 2 : 1;
    if (a == lim + 1) return 3;
    return 0;
  endfunction

  function automatic int seq_bad();
    int bad;
    int n;
    bad = 0;
    first_bad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    if (got_q.size() != exp_q.size()) begin
      if (bad == 0) first_bad = n;
      bad += (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    end
    return bad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    mdl_bin = 0;  mdl_band = 0;
    cnt_d = 0;    cnt_p = 0;
    exp_sym = 0;  exp_sync = 0;
    exp_nd = 0;   exp_np = 0;
    sym_cnt = 0;  sync_cnt = 0;
    stall_viol = 0;
    first_valid_cyc = -1;
  endtask

  task automatic send_bin(input logic [2:0] bw, input logic last, input logic [DW-1:0] vi,
                          input logic [DW-1:0] vq);
    logic acc;
    int   waits;
    int   idx;
    int   code;
    s_valid  = 1'b1;
    s_i      = vi;
    s_q      = vq;
    s_last   = last;
    index_bw = bw;
    acc      = 1'b0;
    waits    = 0;
    while (!acc) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        acc = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      waits++;
      if (!acc && waits > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: s_ready low for %0d cycles, required 1", waits);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    idx = mdl_bin;
    if (idx == 0) mdl_band = int'(bw);
    code = ref_code(mdl_band, idx);
    if (code == 1 || code == 2) begin
      exp_q.push_back({code == 2, DEPTH'(idx), vi, vq});
      if (code == 1) cnt_d++;
      else cnt_p++;
    end
    if (last != (idx == N - 1)) begin
      exp_sync++;
      mdl_bin = 0;
    end else begin
      mdl_bin = (idx + 1) % N;
    end
    if (idx == N - 1) begin
      exp_sym++;
      exp_nd = STATS ? cnt_d : 0;
      exp_np = STATS ? cnt_p : 0;
      cnt_d = 0;
      cnt_p = 0;
    end
  endtask

  // Sends `count` bins with correct framing; gaps of up to gap_max idle cycles.
  task automatic send_range(input logic [2:0] bw, input int count, input int gap_max,
                            input bit idx_data);
    logic [DW-1:0] vi;
    int gap;
    for (int k = 0; k < count; k++) begin
      vi = idx_data ? DW'(mdl_bin) : DW'($urandom);
      send_bin(bw, mdl_bin == N - 1, vi, DW'($urandom));
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (got_q.size() < exp_q.size()) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d carriers, required %0d", got_q.size(), exp_q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    checks++; if (m_idx !== '0) begin errors++; $display("FAIL reset_m_idx: got %0d required 0", m_idx); end
    checks++; if (m_pilot !== 1'b0) begin errors++; $display("FAIL reset_m_pilot: got %b required 0", m_pilot); end
    checks++; if (sym_done !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b required 00", sym_done, sync_err); end
    checks++; if (n_data !== '0 || n_pilot !== '0) begin errors++; $display("FAIL reset_counts: got %0d/%0d required 0/0", n_data, n_pilot); end
  endtask

  task automatic test_band0();
    int t1;
    int bad;
    do_reset();
    rdy_mode = 0;
    send_range(3'd0, 1, 0, 1'b1);
    send_range(3'd0, 1, 0, 1'b1);
    t1 = acc_cyc;
    send_range(3'd0, N - 2, 0, 1'b1);
    drain();
    checks++; if (first_valid_cyc !== t1 + 2) begin errors++; $display("FAIL band0_latency: first m_valid at cycle %0d required %0d", first_valid_cyc, t1 + 2); end
    bad = seq_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL band0_seq: %0d bad, first at %0d got %h required %h", bad, first_bad, got_q[first_bad], exp_q[first_bad]); end
    checks++; if (sym_cnt !== 1) begin errors++; $display("FAIL band0_sym_done: got %0d pulses required 1", sym_cnt); end
    checks++; if (sync_cnt !== 0) begin errors++; $display("FAIL band0_sync_err: got %0d pulses required 0", sync_cnt); end
    checks++; if (n_data !== (DEPTH+1)'(exp_nd)) begin errors++; $display("FAIL band0_n_data: got %0d required %0d", n_data, exp_nd); end
    checks++; if (n_pilot !== (DEPTH+1)'(exp_np)) begin errors++; $display("FAIL band0_n_pilot: got %0d required %0d", n_pilot, exp_np); end
  endtask

  task automatic test_stall_band3();
    int bad;
    do_reset();
    rdy_mode = 1;
    send_range(3'd3, N, 0, 1'b0);
    drain();
    rdy_mode = 0;
    bad = seq_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_seq: %0d bad, first at %0d got %h required %h", bad, first_bad, got_q[first_bad], exp_q[first_bad]); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles required 0", stall_viol); end
    checks++; if (sym_cnt !== 1) begin errors++; $display("FAIL stall_sym_done: got %0d pulses required 1", sym_cnt); end
    checks++; if (n_data !== (DEPTH+1)'(exp_nd) || n_pilot !== (DEPTH+1)'(exp_np)) begin errors++; $display("FAIL stall_counts: got %0d/%0d required %0d/%0d", n_data, n_pilot, exp_nd, exp_np); end
  endtask

  task automatic test_bw_change();
    int bad;
    do_reset();
    rdy_mode = 0;
    send_range(3'd0, 500, 0, 1'b0);
    send_range(3'd5, N - 500, 0, 1'b0);
    drain();
    checks++; if (n_data !== (DEPTH+1)'(exp_nd) || n_pilot !== (DEPTH+1)'(exp_np)) begin errors++; $display("FAIL bwchg_counts_sym1: got %0d/%0d required %0d/%0d", n_data, n_pilot, exp_nd, exp_np); end
    send_range(3'd5, N, 0, 1'b0);
    drain();
    bad = seq_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL bwchg_seq: %0d bad, first at %0d got %h required %h", bad, first_bad, got_q[first_bad], exp_q[first_bad]); end
    checks++; if (n_data !== (DEPTH+1)'(exp_nd) || n_pilot !== (DEPTH+1)'(exp_np)) begin errors++; $display("FAIL bwchg_counts_sym2: got %0d/%0d required %0d/%0d", n_data, n_pilot, exp_nd, exp_np); end
    checks++; if (sym_cnt !== 2) begin errors++; $display("FAIL bwchg_sym_done: got %0d pulses required 2", sym_cnt); end
  endtask

  task automatic test_sync();
    int bad;
    do_reset();
    rdy_mode = 2;
    send_range(3'd2, 700, 1, 1'b0);
    send_bin(3'd2, 1'b1, DW'($urandom), DW'($urandom));
    drain();
    checks++; if (sync_cnt !== 1) begin errors++; $display("FAIL sync_early_err: got %0d pulses required 1", sync_cnt); end
    checks++; if (sym_cnt !== 0) begin errors++; $display("FAIL sync_early_sym_done: got %0d pulses required 0", sym_cnt); end
    send_range(3'd4, N, 1, 1'b0);
    send_range(3'd4, N - 1, 0, 1'b0);
    send_bin(3'd4, 1'b0, DW'($urandom), DW'($urandom));
    send_range(3'd1, 10, 0, 1'b0);
    drain();
    rdy_mode = 0;
    bad = seq_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL sync_seq: %0d bad, first at %0d got %h required %h", bad, first_bad, got_q[first_bad], exp_q[first_bad]); end
    checks++; if (sync_cnt !== exp_sync) begin errors++; $display("FAIL sync_err_count: got %0d required %0d", sync_cnt, exp_sync); end
    checks++; if (sym_cnt !== exp_sym) begin errors++; $display("FAIL sync_sym_done: got %0d required %0d", sym_cnt, exp_sym); end
    checks++; if (n_data !== (DEPTH+1)'(exp_nd)) begin errors++; $display("FAIL sync_n_data: got %0d required %0d", n_data, exp_nd); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    rdy_mode = 0;
    send_range(3'd5, N + 301, 0, 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b required 1", m_valid); end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid: got %b required 0", m_valid); end
    checks++; if (n_data !== '0 || n_pilot !== '0) begin errors++; $display("FAIL rstmid_counts: got %0d/%0d required 0/0", n_data, n_pilot); end
    do_reset();
    send_range(3'd5, N, 0, 1'b0);
    drain();
    bad = seq_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_seq: %0d bad, first at %0d got %h required %h", bad, first_bad, got_q[first_bad], exp_q[first_bad]); end
    checks++; if (n_data !== (DEPTH+1)'(exp_nd) || n_pilot !== (DEPTH+1)'(exp_np)) begin errors++; $display("FAIL rstmid_counts_after: got %0d/%0d required %0d/%0d", n_data, n_pilot, exp_nd, exp_np); end
  endtask

  task automatic test_null_band();
    do_reset();
    rdy_mode = 0;
    send_range(3'd1, N, 0, 1'b0);
    drain();
    checks++; if (n_data !== (DEPTH+1)'(exp_nd)) begin errors++; $display("FAIL null_pre_n_data: got %0d required %0d", n_data, exp_nd); end
    got_q.delete();
    exp_q.delete();
    send_range(3'd7, N, 0, 1'b0);
    drain();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL null_outputs: got %0d carriers required 0", got_q.size()); end
    checks++; if (sym_cnt !== 2) begin errors++; $display("FAIL null_sym_done: got %0d pulses required 2", sym_cnt); end
    checks++; if (n_data !== '0 || n_pilot !== '0) begin errors++; $display("FAIL null_counts: got %0d/%0d required 0/0", n_data, n_pilot); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    rdy_mode = 2;
    for (int s = 0; s < 3; s++) begin
      send_range(3'($urandom_range(0, 7)), N, 2, 1'b0);
    end
    drain();
    rdy_mode = 0;
    bad = seq_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL random_seq: %0d bad, first at %0d got %h required %h", bad, first_bad, got_q[first_bad], exp_q[first_bad]); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL random_stable: got %0d unstable cycles required 0", stall_viol); end
    checks++; if (sym_cnt !== exp_sym) begin errors++; $display("FAIL random_sym_done: got %0d required %0d", sym_cnt, exp_sym); end
    checks++; if (n_data !== (DEPTH+1)'(exp_nd) || n_pilot !== (DEPTH+1)'(exp_np)) begin errors++; $display("FAIL random_counts: got %0d/%0d required %0d/%0d", n_data, n_pilot, exp_nd, exp_np); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_band0();
    test_stall_band3();
    test_bw_change();
    test_sync();
    test_reset_mid();
    test_null_band();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
